// File: rtl/math_round_sequencer.sv
// math_round_sequencer: round FSM for the math game. Fetches operands from the RNG,
// runs the per-round countdown, judges the answer, shows the result and keeps score.
module math_round_sequencer #(
  parameter  int unsigned W          = 4,
  parameter  int unsigned ROUNDS     = 8,
  parameter  int unsigned TIME_LIMIT = 10,
  parameter  int unsigned SHOW_SECS  = 2,
  localparam int unsigned RW         = $clog2(ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              submit,
  input  logic [W:0]        answer,
  output logic              rng_req,
  input  logic              rng_valid,
  input  logic [2*W-1:0]    rng_data,
  input  logic              tick_1s,
  output logic              timer_enable,
  output logic [W-1:0]      operand_a,
  output logic [W-1:0]      operand_b,
  output logic [7:0]        time_left,
  output logic [RW-1:0]     round,
  output logic [RW-1:0]     score,
  output logic              green_led,
  output logic              red_led,
  output logic              game_over
);

  localparam int unsigned AW = W + 1;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = $clog2(SHOW_SECS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_CHECK,
    S_SHOW,
    S_DONE
  } state_t;

  state_t          state_q, state_d;

  logic [AW-1:0]   answer_q, answer_d;
  logic            timeout_q, timeout_d;
  logic [SW-1:0]   show_cnt_q, show_cnt_d;

  logic            rng_req_d;
  logic            timer_enable_d;
  logic [W-1:0]    operand_a_d, operand_b_d;
  logic [TW-1:0]   time_left_d;
  logic [RW-1:0]   round_d, score_d;
  logic            green_d, red_d, game_over_d;

  logic [AW-1:0]   sum_c;
  logic            correct_c;

  // Sum is one bit wider than the operands, so it never overflows.
  assign sum_c     = AW'(operand_a) + AW'(operand_b);
  assign correct_c = !timeout_q && (answer_q == sum_c);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      answer_q     <= '0;
      timeout_q    <= 1'b0;
      show_cnt_q   <= '0;
      rng_req      <= 1'b0;
      timer_enable <= 1'b0;
      operand_a    <= '0;
      operand_b    <= '0;
      time_left    <= '0;
      round        <= '0;
      score        <= '0;
      green_led    <= 1'b0;
      red_led      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_d;
      answer_q     <= answer_d;
      timeout_q    <= timeout_d;
      show_cnt_q   <= show_cnt_d;
      rng_req      <= rng_req_d;
      timer_enable <= timer_enable_d;
      operand_a    <= operand_a_d;
      operand_b    <= operand_b_d;
      time_left    <= time_left_d;
      round        <= round_d;
      score        <= score_d;
      green_led    <= green_d;
      red_led      <= red_d;
      game_over    <= game_over_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    answer_d       = answer_q;
    timeout_d      = timeout_q;
    show_cnt_d     = show_cnt_q;
    rng_req_d      = 1'b0;
    timer_enable_d = 1'b0;
    operand_a_d    = operand_a;
    operand_b_d    = operand_b;
    time_left_d    = time_left;
    round_d        = round;
    score_d        = score;
    green_d        = green_led;
    red_d          = red_led;
    game_over_d    = game_over;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          round_d = '0;
          score_d = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (rng_valid) begin
          operand_a_d = rng_data[2*W-1:W];
          operand_b_d = rng_data[W-1:0];
          time_left_d = TW'(TIME_LIMIT);
          state_d     = S_PLAY;
        end
      end

      S_PLAY: begin
        if (tick_1s) begin
          time_left_d = time_left - TW'(1);
        end
        // A submit in the same cycle as the final tick still gets judged.
        if (submit) begin
          answer_d  = answer;
          timeout_d = 1'b0;
          state_d   = S_CHECK;
        end else if (tick_1s && (time_left == TW'(1))) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        green_d = correct_c;
        red_d   = !correct_c;
        if (correct_c && (score < RW'(ROUNDS))) begin
          score_d = score + RW'(1);
        end
        show_cnt_d = SW'(SHOW_SECS);
        state_d    = S_SHOW;
      end

      S_SHOW: begin
        if (tick_1s) begin
          show_cnt_d = show_cnt_q - SW'(1);
          if (show_cnt_q == SW'(1)) begin
            green_d = 1'b0;
            red_d   = 1'b0;
            if (round == RW'(ROUNDS - 1)) begin
              game_over_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              round_d = round + RW'(1);
              state_d = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        if (start) begin
          round_d     = '0;
          score_d     = '0;
          game_over_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request and timer enable follow the state being entered, so both are registered.
    rng_req_d      = (state_d == S_FETCH);
    timer_enable_d = (state_d == S_PLAY) || (state_d == S_SHOW);
  end

endmodule

// File: tb/tb_math_round_sequencer.sv
// tb_math_round_sequencer: table-driven rounds with a result scoreboard, plus hand
// sequences for reset mid-round, ignored pulses and game restart.
module tb_math_round_sequencer;

  localparam int unsigned W          = 4;
  localparam int unsigned ROUNDS     = 8;
  localparam int unsigned TIME_LIMIT = 10;
  localparam int unsigned SHOW_SECS  = 2;
  localparam int unsigned RW         = $clog2(ROUNDS + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           submit = 1'b0;
  logic [W:0]     answer = '0;
  logic           rng_req;
  logic           rng_valid = 1'b0;
  logic [2*W-1:0] rng_data = '0;
  logic           tick_1s = 1'b0;
  logic           timer_enable;
  logic [W-1:0]   operand_a, operand_b;
  logic [7:0]     time_left;
  logic [RW-1:0]  round, score;
  logic           green_led, red_led, game_over;

  math_round_sequencer #(
    .W(W), .ROUNDS(ROUNDS), .TIME_LIMIT(TIME_LIMIT), .SHOW_SECS(SHOW_SECS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .submit(submit), .answer(answer),
    .rng_req(rng_req), .rng_valid(rng_valid), .rng_data(rng_data),
    .tick_1s(tick_1s), .timer_enable(timer_enable),
    .operand_a(operand_a), .operand_b(operand_b), .time_left(time_left),
    .round(round), .score(score), .green_led(green_led), .red_led(red_led),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          green;
    logic          red;
    logic [RW-1:0] score;
    logic [7:0]    time_left;
  } exp_t;

  // mode 0: submit after n_ticks ticks; 1: timeout; 2: submit with the final tick
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   ans;
    int           mode;
    int           n_ticks;
    logic         exp_green;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic led_prev = 1'b0;

  int score_m = 0;
  int round_m = 0;
  logic [W-1:0] op_a_m = '0;
  logic [W-1:0] op_b_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
  endtask

  // Scoreboard: each rising result LED consumes one expected record.
  always @(negedge clk) begin
    if (!rst) begin
      led_prev = 1'b0;
    end else begin
      if ((green_led || red_led) && !led_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: result LED rose with nothing expected at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_green", 32'(green_led), 32'(mon_e.green));
          chk("sb_red", 32'(red_led), 32'(mon_e.red));
          chk("sb_score", 32'(score), 32'(mon_e.score));
          chk("sb_time_left", 32'(time_left), 32'(mon_e.time_left));
        end
      end
      led_prev = green_led || red_led;
    end
  end

  task automatic play_round(input vec_t v, input bit poke);
    exp_t e;
    int   tl_exp;
    chk("fetch_rng_req", 32'(rng_req), 32'd1);
    chk("fetch_timer_en", 32'(timer_enable), 32'd0);
    chk("fetch_round", 32'(round), 32'(round_m));
    chk("fetch_hold_a", 32'(operand_a), 32'(op_a_m));
    chk("fetch_hold_b", 32'(operand_b), 32'(op_b_m));
    if (poke) begin
      answer = v.ans;
      submit = 1'b1;
      step();
      submit = 1'b0;
      step();
      step();
      chk("poke_fetch_rng_req", 32'(rng_req), 32'd1);
      chk("poke_fetch_score", 32'(score), 32'(score_m));
      chk("poke_fetch_led", 32'(green_led | red_led), 32'd0);
      chk("poke_fetch_a", 32'(operand_a), 32'(op_a_m));
    end
    rng_data  = {v.a, v.b};
    rng_valid = 1'b1;
    step();
    rng_valid = 1'b0;
    op_a_m = v.a;
    op_b_m = v.b;
    chk("load_a", 32'(operand_a), 32'(v.a));
    chk("load_b", 32'(operand_b), 32'(v.b));
    chk("load_time_left", 32'(time_left), 32'(TIME_LIMIT));
    chk("load_rng_req", 32'(rng_req), 32'd0);
    chk("play_timer_en", 32'(timer_enable), 32'd1);
    if (poke) begin
      start = 1'b1;
      step();
      start = 1'b0;
      rng_data  = {~v.a, ~v.b};
      rng_valid = 1'b1;
      step();
      rng_valid = 1'b0;
      step();
      chk("poke_play_a", 32'(operand_a), 32'(v.a));
      chk("poke_play_b", 32'(operand_b), 32'(v.b));
      chk("poke_play_time_left", 32'(time_left), 32'(TIME_LIMIT));
      chk("poke_play_round", 32'(round), 32'(round_m));
      chk("poke_play_score", 32'(score), 32'(score_m));
      chk("poke_play_rng_req", 32'(rng_req), 32'd0);
      chk("poke_play_timer_en", 32'(timer_enable), 32'd1);
    end

    if (v.exp_green && score_m < int'(ROUNDS)) score_m++;
    e.green = v.exp_green;
    e.red   = !v.exp_green;
    e.score = RW'(score_m);

    if (v.mode == 0) begin
      tl_exp = int'(TIME_LIMIT) - v.n_ticks;
      for (int t = 0; t < v.n_ticks; t++) tick();
      chk("play_time_left", 32'(time_left), 32'(tl_exp));
      e.time_left = 8'(tl_exp);
      sb_q.push_back(e);
      answer = v.ans;
      submit = 1'b1;
      step();
      submit = 1'b0;
    end else begin
      tl_exp = 0;
      for (int t = 0; t < int'(TIME_LIMIT) - 1; t++) tick();
      chk("last_sec_time_left", 32'(time_left), 32'd1);
      chk("last_sec_timer_en", 32'(timer_enable), 32'd1);
      e.time_left = 8'd0;
      sb_q.push_back(e);
      answer  = v.ans;
      tick_1s = 1'b1;
      submit  = (v.mode == 2);
      step();
      tick_1s = 1'b0;
      submit  = 1'b0;
    end

    chk("check_timer_en", 32'(timer_enable), 32'd0);
    chk("check_led_off", 32'(green_led | red_led), 32'd0);
    chk("check_time_left", 32'(time_left), 32'(tl_exp));
    step();
    chk("show_green", 32'(green_led), 32'(v.exp_green));
    chk("show_red", 32'(red_led), 32'(!v.exp_green));
    chk("show_score", 32'(score), 32'(score_m));
    chk("show_timer_en", 32'(timer_enable), 32'd1);

    for (int s = 0; s < int'(SHOW_SECS) - 1; s++) begin
      tick();
      chk("show_hold_led", 32'(green_led | red_led), 32'd1);
    end
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    chk("show_end_led", 32'(green_led | red_led), 32'd0);
    chk("show_end_timer_en", 32'(timer_enable), 32'd0);
    if (round_m == int'(ROUNDS) - 1) begin
      chk("done_game_over", 32'(game_over), 32'd1);
      chk("done_rng_req", 32'(rng_req), 32'd0);
      chk("done_round", 32'(round), 32'(ROUNDS - 1));
    end else begin
      round_m++;
      chk("next_rng_req", 32'(rng_req), 32'd1);
      chk("next_round", 32'(round), 32'(round_m));
      chk("next_game_over", 32'(game_over), 32'd0);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rng_req, timer_enable, operand_a, operand_b, time_left,
                round, score, green_led, red_led, game_over});
  endfunction

  initial begin
    vec_t vecs[8];
    vec_t v;

    vecs[0] = '{a: 4'd7,  b: 4'd9,  ans: 5'd16, mode: 0, n_ticks: 3, exp_green: 1'b1};
    vecs[1] = '{a: 4'd7,  b: 4'd9,  ans: 5'd15, mode: 0, n_ticks: 0, exp_green: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd4,  ans: 5'd7,  mode: 1, n_ticks: 0, exp_green: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, ans: 5'd30, mode: 2, n_ticks: 0, exp_green: 1'b1};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  ans: 5'd0,  mode: 0, n_ticks: 1, exp_green: 1'b1};
    vecs[5] = '{a: 4'd15, b: 4'd1,  ans: 5'd16, mode: 1, n_ticks: 0, exp_green: 1'b0};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  ans: 5'd16, mode: 0, n_ticks: 9, exp_green: 1'b1};
    vecs[7] = '{a: 4'd9,  b: 4'd6,  ans: 5'd14, mode: 2, n_ticks: 0, exp_green: 1'b0};

    // Reset and idle behaviour
    repeat (3) step();
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_outputs", all_outs(), 32'd0);
    submit = 1'b1; tick_1s = 1'b1; rng_valid = 1'b1; rng_data = 8'hAB;
    step();
    submit = 1'b0; tick_1s = 1'b0; rng_valid = 1'b0;
    step();
    chk("idle_ignored", all_outs(), 32'd0);

    // Game 1: table vectors, with ignored pulses poked in round 1
    start = 1'b1;
    step();
    start = 1'b0;
    score_m = 0;
    round_m = 0;
    chk("start_score", 32'(score), 32'd0);
    for (int i = 0; i < 8; i++) play_round(vecs[i], i == 1);
    chk("game1_score", 32'(score), 32'd4);

    // DONE ignores ticks and submits
    tick_1s = 1'b1; submit = 1'b1;
    step();
    tick_1s = 1'b0; submit = 1'b0;
    step();
    chk("done_timer_en", 32'(timer_enable), 32'd0);
    chk("done_leds", 32'(green_led | red_led), 32'd0);
    chk("done_hold_score", 32'(score), 32'd4);
    chk("done_hold_game_over", 32'(game_over), 32'd1);

    // Game 2: all correct, random operands
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_round", 32'(round), 32'd0);
    chk("restart_game_over", 32'(game_over), 32'd0);
    score_m = 0;
    round_m = 0;
    for (int i = 0; i < 8; i++) begin
      v.a = W'($urandom_range(0, 15));
      v.b = W'($urandom_range(0, 15));
      v.ans = (W + 1)'(v.a) + (W + 1)'(v.b);
      v.mode = (i % 3 == 1) ? 2 : 0;
      v.n_ticks = i;
      v.exp_green = 1'b1;
      play_round(v, 1'b0);
    end
    chk("game2_score", 32'(score), 32'(ROUNDS));
    chk("game2_round", 32'(round), 32'(ROUNDS - 1));
    chk("game2_game_over", 32'(game_over), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("game3_start_score", 32'(score), 32'd0);
    chk("game3_start_rng_req", 32'(rng_req), 32'd1);

    // Game 3: reset in the middle of round 3
    score_m = 0;
    round_m = 0;
    for (int i = 0; i < 3; i++) begin
      v = vecs[0];
      play_round(v, 1'b0);
    end
    rng_data = {4'd2, 4'd5};
    rng_valid = 1'b1;
    step();
    rng_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_time_left", 32'(time_left), 32'(TIME_LIMIT - 2));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_reset_idle", all_outs(), 32'd0);
    op_a_m = '0;
    op_b_m = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    score_m = 0;
    round_m = 0;
    chk("post_reset_round", 32'(round), 32'd0);
    play_round(vecs[3], 1'b0);
    chk("post_reset_score", 32'(score), 32'd1);

    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/math_round_sequencer.md
# math_round_sequencer

Round sequencer for the math game. It fetches two operands from the random-number generator and starts the per-round countdown, which advances on the one-second tick. It then waits for the player's answer, judges it, drives the result LEDs, and keeps score across a fixed number of rounds. It sits between the RNG, the one-second timer and the button/switch front end, and is the single owner of the timer enable.

## Interface
- W, 4: operand width; answer and sum are W+1 bits.
- ROUNDS, 8: rounds per game, minimum 1.
- TIME_LIMIT, 10: seconds allowed per round, range 1..255.
- SHOW_SECS, 2: seconds the result LED is held, minimum 1.
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle pulse, already debounced: begin a game.
- submit  in  1  one-cycle pulse, already debounced: answer is valid.
- answer  in  W+1  player answer from the toggle switches.
- rng_req  out  1  request operands from the RNG.
- rng_valid  in  1  RNG data is valid; one-cycle pulse.
- rng_data  in  2W  {a, b} from the RNG.
- tick_1s  in  1  one-cycle pulse from the one-second timer.
- timer_enable  out  1  runs the one-second timer.
- operand_a, operand_b  out  W  current operands, for the display.
- time_left  out  8  seconds remaining in the round.
- round  out  clog2(ROUNDS+1)  index of the current round, starting at 0.
- score  out  clog2(ROUNDS+1)  count of correct answers.
- green_led, red_led  out  1  correct / wrong-or-timeout indication.
- game_over  out  1  final score is being shown.

## Operation
- States: IDLE, FETCH, PLAY, CHECK, SHOW, DONE. All outputs are registered.
- Reset: asserting rst forces IDLE at any time, including mid-round. Every output resets to 0.
- IDLE: all outputs are 0. A start pulse clears round and score, then moves to FETCH.
- FETCH: rng_req is held high until rng_valid arrives.
  - On rng_valid: operand_a = rng_data[2W-1:W], operand_b = rng_data[W-1:0], time_left = TIME_LIMIT, rng_req drops, next state PLAY.
  - rng_valid arriving in any other state is ignored.
- PLAY: timer_enable = 1.
  - Each tick_1s decrements time_left.
  - A submit pulse latches answer and moves to CHECK.
  - A tick_1s while time_left == 1 sets time_left to 0 and moves to CHECK with a timeout flag.
  - If submit and the final tick arrive in the same cycle, submit wins and the answer is judged. time_left still goes to 0.
- CHECK: lasts one cycle; timer_enable = 0.
  - correct = no timeout AND latched answer == operand_a + operand_b, computed at W+1 bits with no overflow.
  - If correct, score increments; score never exceeds ROUNDS.
  - Next state SHOW, with the show counter loaded to SHOW_SECS.
- SHOW: green_led = correct, red_led = !correct; timer_enable = 1.
  - Each tick_1s decrements the show counter.
  - When the counter reaches 0, both LEDs drop.
  - If round == ROUNDS-1, next state DONE; otherwise round increments and next state FETCH.
- DONE: game_over = 1. score and round hold their values; the LEDs and timer_enable are 0.
  - A start pulse clears score, round and game_over, then moves to FETCH.
- Pulses ignored outside their states: start outside IDLE/DONE, submit outside PLAY, tick_1s outside PLAY/SHOW. The operands hold their values until the next rng_valid.

## Timing
- A start pulse sampled at edge k gives rng_req = 1 after edge k.
- rng_valid at edge k gives PLAY and loaded operands after edge k.
- A submit sampled at edge k gives CHECK after k, and the LED plus the updated score after k+1. Submit-to-LED latency is 2 cycles.
- Timeout: with no submit, CHECK is entered exactly TIME_LIMIT ticks after PLAY is entered.
- The LED is held for SHOW_SECS ticks. It drops on the same edge that enters FETCH or DONE.
- timer_enable is deasserted for exactly one cycle between PLAY and SHOW, which restarts the one-second timer. It is also low in IDLE, FETCH and DONE.
- rng_req stays high indefinitely while rng_valid is absent; there is no timeout.

## Test plan
- Reset mid-PLAY: assert rst during round 3 -> every output is 0 immediately, state IDLE. start then begins round 0 with score 0.
- Correct answer: rng_data = {4'd7, 4'd9}, answer = 16, submit -> green_led = 1 two cycles after submit, score = 1. The LED holds for 2 ticks.
- Wrong answer, then timeout: answer = 15 -> red_led = 1, score unchanged. In the next round, send no submit for 10 ticks -> red_led = 1, time_left = 0.
- Submit together with the final tick: time_left = 1, submit and tick_1s in the same cycle, answer correct -> green_led = 1, score increments.
- Full game, ROUNDS = 8, all correct -> game_over = 1 after the 8th SHOW, score = 8, round = 7. start -> score = 0, rng_req = 1.
- Ignored inputs: submit in FETCH, start in PLAY, rng_valid in PLAY -> no state, score or operand change.
